// File: rtl/tile_span_sched.sv
// rtl/tile_span_sched.sv - walks one 32x32 tile row by row and emits a span per non-empty row.
// Optional per-tile span/pixel counters: define TILE_SPAN_STATS_EN.
module tile_span_sched #(
    parameter int TILE_ROWS = 32,
    parameter int COORD_W   = 11
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [5:0]         tile_x_i,
    input  logic [5:0]         tile_y_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [COORD_W-1:0] eval_x_o,
    output logic [COORD_W-1:0] eval_y_o,
    input  logic [31:0]        eval_mask_i,
    input  logic [4:0]         eval_lz_i,
    input  logic [4:0]         eval_tz_i,
    output logic               span_valid_o,
    input  logic               span_ready_i,
    output logic [COORD_W-1:0] span_y_o,
    output logic [COORD_W-1:0] span_x0_o,
    output logic [COORD_W-1:0] span_x1_o,
    output logic [31:0]        span_mask_o,
    output logic [10:0]        stat_pixels_o,
    output logic [5:0]         stat_spans_o
);

    localparam int ROW_W = (TILE_ROWS > 1) ? $clog2(TILE_ROWS) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(TILE_ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_EVAL,
        S_EMIT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [5:0]         tile_x_q, tile_x_d;
    logic [5:0]         tile_y_q, tile_y_d;
    logic [COORD_W-1:0] span_y_q, span_y_d;
    logic [COORD_W-1:0] span_x0_q, span_x0_d;
    logic [COORD_W-1:0] span_x1_q, span_x1_d;
    logic [31:0]        span_mask_q, span_mask_d;
    logic [COORD_W-1:0] base_x, base_y;
    logic               accept, handshake;

    assign base_x   = COORD_W'({tile_x_q, 5'd0});
    assign base_y   = COORD_W'({tile_y_q, 5'd0});
    assign eval_x_o = base_x;
    assign eval_y_o = base_y + COORD_W'(row_q);

    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = (state_q == S_DONE);
    assign span_valid_o = (state_q == S_EMIT);
    assign span_y_o     = span_y_q;
    assign span_x0_o    = span_x0_q;
    assign span_x1_o    = span_x1_q;
    assign span_mask_o  = span_mask_q;

    // Abort overrides both a fresh start and an in-flight handshake.
    assign accept    = (state_q == S_IDLE) && start_i && !abort_i;
    assign handshake = (state_q == S_EMIT) && span_ready_i && !abort_i;

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        tile_x_d    = tile_x_q;
        tile_y_d    = tile_y_q;
        span_y_d    = span_y_q;
        span_x0_d   = span_x0_q;
        span_x1_d   = span_x1_q;
        span_mask_d = span_mask_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    tile_x_d = tile_x_i;
                    tile_y_d = tile_y_i;
                    row_d    = '0;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: state_d = S_EVAL;
            S_EVAL: begin
                span_y_d    = eval_y_o;
                span_x0_d   = base_x + COORD_W'(eval_lz_i);
                span_x1_d   = base_x + COORD_W'(31) - COORD_W'(eval_tz_i);
                span_mask_d = eval_mask_i;
                if (eval_mask_i != 32'd0) begin
                    state_d = S_EMIT;
                end else if (row_q == LAST_ROW) begin
                    state_d = S_DONE;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            S_EMIT: begin
                if (span_ready_i) begin
                    if (row_q == LAST_ROW) begin
                        state_d = S_DONE;
                    end else begin
                        row_d   = row_q + 1'b1;
                        state_d = S_EVAL;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            tile_x_q    <= '0;
            tile_y_q    <= '0;
            span_y_q    <= '0;
            span_x0_q   <= '0;
            span_x1_q   <= '0;
            span_mask_q <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            tile_x_q    <= tile_x_d;
            tile_y_q    <= tile_y_d;
            span_y_q    <= span_y_d;
            span_x0_q   <= span_x0_d;
            span_x1_q   <= span_x1_d;
            span_mask_q <= span_mask_d;
        end
    end

`ifdef TILE_SPAN_STATS_EN
    logic [10:0] stat_pixels_q;
    logic [5:0]  stat_spans_q;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            stat_pixels_q <= '0;
            stat_spans_q  <= '0;
        end else if (accept) begin
            stat_pixels_q <= '0;
            stat_spans_q  <= '0;
        end else if (handshake) begin
            stat_pixels_q <= stat_pixels_q + 11'(span_x1_q - span_x0_q + 1'b1);
            stat_spans_q  <= stat_spans_q + 6'd1;
        end
    end

    assign stat_pixels_o = stat_pixels_q;
    assign stat_spans_o  = stat_spans_q;
`else
    assign stat_pixels_o = '0;
    assign stat_spans_o  = '0;
`endif

endmodule

// File: tb/tb_tile_span_sched.sv
// tb/tb_tile_span_sched.sv - randomized self-checking bench for tile_span_sched.
module tb_tile_span_sched;

    localparam int CW = 11;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [5:0]    tile_x = '0;
    logic [5:0]    tile_y = '0;
    logic          busy, done, span_valid;
    logic          span_ready = 1'b0;
    logic [CW-1:0] eval_x, eval_y, span_y, span_x0, span_x1;
    logic [31:0]   eval_mask, span_mask;
    logic [4:0]    eval_lz, eval_tz;
    logic [10:0]   stat_pixels;
    logic [5:0]    stat_spans;

    int checks = 0;
    int errors = 0;

    logic [31:0] row_mask [32];
    logic        rdy_pat [1024];

    always #5 clock = ~clock;

    tile_span_sched #(.TILE_ROWS(32), .COORD_W(CW)) dut (
        .clock_i(clock), .reset_i(reset), .start_i(start), .abort_i(abort),
        .tile_x_i(tile_x), .tile_y_i(tile_y), .busy_o(busy), .done_o(done),
        .eval_x_o(eval_x), .eval_y_o(eval_y), .eval_mask_i(eval_mask),
        .eval_lz_i(eval_lz), .eval_tz_i(eval_tz), .span_valid_o(span_valid),
        .span_ready_i(span_ready), .span_y_o(span_y), .span_x0_o(span_x0),
        .span_x1_o(span_x1), .span_mask_o(span_mask),
        .stat_pixels_o(stat_pixels), .stat_spans_o(stat_spans)
    );

    function automatic logic [4:0] zeros_lo(input logic [31:0] m);
        int n = 0;
        for (int i = 31; i >= 0; i--) if (m[i]) n = i;
        return 5'(n);
    endfunction

    function automatic logic [4:0] zeros_hi(input logic [31:0] m);
        int n = 31;
        for (int i = 0; i < 32; i++) if (m[i]) n = i;
        return 5'(31 - n);
    endfunction

    // Evaluator stand-in: row within tile is the low five bits of y.
    always_comb begin
        eval_mask = row_mask[eval_y[4:0]];
        eval_lz   = zeros_lo(eval_mask);
        eval_tz   = zeros_hi(eval_mask);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_valid"}, span_valid, 0);
        check({tag, "_eval_x"}, eval_x, 0);
        check({tag, "_eval_y"}, eval_y, 0);
        check({tag, "_span_y"}, span_y, 0);
        check({tag, "_span_x0"}, span_x0, 0);
        check({tag, "_span_x1"}, span_x1, 0);
        check({tag, "_span_mask"}, span_mask, 0);
        check({tag, "_stat_pix"}, stat_pixels, 0);
        check({tag, "_stat_spans"}, stat_spans, 0);
    endtask

    function automatic logic [31:0] rand_mask();
        int lo, hi;
        logic [31:0] m = '0;
        case ($urandom_range(0, 3))
            0: m = '0;
            1: m = '1;
            2: begin
                lo = $urandom_range(0, 31);
                hi = $urandom_range(lo, 31);
                for (int i = lo; i <= hi; i++) m[i] = 1'b1;
            end
            default: m = $urandom;
        endcase
        return m;
    endfunction

    // Reference: walk the tile with the row-cost rules and predict every span and the done cycle.
    task automatic run_tile(input int tx, input int ty, input bit chk_steps);
        int q_y[$], q_x0[$], q_x1[$], q_t[$];
        logic [31:0] q_m[$];
        int t = 2, pix = 0, nspan = 0, exp_done, cyc;
        bit done_seen = 0;
        for (int r = 0; r < 32; r++) begin
            logic [31:0] m = row_mask[r];
            t++;
            if (m != 0) begin
                while (!rdy_pat[t]) t++;
                q_y.push_back(ty * 32 + r);
                q_x0.push_back(tx * 32 + zeros_lo(m));
                q_x1.push_back(tx * 32 + 31 - zeros_hi(m));
                q_m.push_back(m);
                q_t.push_back(t);
                pix += 32 - zeros_lo(m) - zeros_hi(m);
                nspan++;
                t++;
            end
        end
        exp_done = t;

        @(posedge clock); #1;
        tile_x = 6'(tx); tile_y = 6'(ty); start = 1'b1; span_ready = rdy_pat[0];
        for (cyc = 1; cyc < 700; cyc++) begin
            @(posedge clock); #1;
            start = 1'b0;
            span_ready = rdy_pat[cyc];
            #1;
            if (chk_steps && cyc >= 2 && cyc <= 33)
                check("eval_y_step", eval_y, ty * 32 + cyc - 2);
            if (span_valid) begin
                if (q_y.size() == 0) begin
                    check("span_unexpected", 1, 0);
                end else begin
                    check("span_y", span_y, q_y[0]);
                    check("span_x0", span_x0, q_x0[0]);
                    check("span_x1", span_x1, q_x1[0]);
                    check("span_mask", span_mask, q_m[0]);
                    check("eval_y_hold", eval_y, q_y[0]);
                    if (span_ready) begin
                        check("hs_cycle", cyc, q_t[0]);
                        void'(q_y.pop_front()); void'(q_x0.pop_front());
                        void'(q_x1.pop_front()); void'(q_m.pop_front());
                        void'(q_t.pop_front());
                    end
                end
            end
            if (done) begin
                done_seen = 1;
                check("done_cycle", cyc, exp_done);
                check("spans_left", q_y.size(), 0);
`ifdef TILE_SPAN_STATS_EN
                check("stat_pixels", stat_pixels, pix);
                check("stat_spans", stat_spans, nspan);
`else
                check("stat_pixels_off", stat_pixels, 0);
                check("stat_spans_off", stat_spans, 0);
`endif
                @(posedge clock); #2;
                check("busy_after_done", busy, 0);
                check("done_pulse_width", done, 0);
                break;
            end
        end
        if (!done_seen) check("done_timeout", 0, 1);
    endtask

    task automatic fill_ready(input int mode);
        for (int i = 0; i < 1024; i++)
            rdy_pat[i] = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        int dones;
        bit hit;
        for (int r = 0; r < 32; r++) row_mask[r] = '0;
        fill_ready(0);

        #12;
        check_all_zero("reset");
        @(negedge clock); reset = 1'b0;

        // All rows empty on tile (3,2).
        run_tile(3, 2, 1);

        // Single span on row 5 of tile (1,0).
        row_mask[5] = 32'h0000_FF00;
        run_tile(1, 0, 0);
        row_mask[5] = '0;

        // Row 0 full with a ten-cycle consumer stall.
        row_mask[0] = '1;
        for (int i = 3; i <= 12; i++) rdy_pat[i] = 1'b0;
        run_tile(5, 7, 0);
        fill_ready(0);

        // Abort while row 3 is being offered.
        for (int r = 0; r < 32; r++) row_mask[r] = '1;
        @(posedge clock); #1;
        tile_x = 6'd4; tile_y = 6'd1; start = 1'b1; span_ready = 1'b1;
        hit = 0;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(posedge clock); #1;
            start = 1'b0;
            span_ready = 1'b1;
            if (span_valid && span_y == 11'(32 + 3)) begin
                span_ready = 1'b0;
                abort = 1'b1;
                @(posedge clock); #1;
                abort = 1'b0;
                check("abort_valid", span_valid, 0);
                check("abort_busy", busy, 0);
                hit = 1;
            end
        end
        check("abort_reached_row3", hit, 1);
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock); #1;
            if (done) dones++;
        end
        check("abort_no_done", dones, 0);
        for (int r = 0; r < 32; r++) row_mask[r] = rand_mask();
        run_tile(0, 0, 0);

        // Asynchronous reset in the middle of EVAL.
        for (int r = 0; r < 32; r++) row_mask[r] = '0;
        row_mask[1] = 32'h00F0_0000;
        @(posedge clock); #1;
        tile_x = 6'd9; tile_y = 6'd9; start = 1'b1;
        @(posedge clock); #1; start = 1'b0; span_ready = 1'b1;
        repeat (5) @(posedge clock);
        #3;
        check("pre_reset_busy", busy, 1);
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        #2;
        reset = 1'b0;
        @(posedge clock); #2;
        check("post_reset_idle", busy, 0);

        // Every row full on tile (2,2).
        for (int r = 0; r < 32; r++) row_mask[r] = '1;
        fill_ready(0);
        run_tile(2, 2, 0);

        // Random tiles with random consumer back-pressure.
        for (int k = 0; k < 6; k++) begin
            for (int r = 0; r < 32; r++) row_mask[r] = rand_mask();
            fill_ready(1);
            run_tile($urandom_range(0, 63), $urandom_range(0, 63), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
